phy_tx_serializer: RTL and testbench

//  Transmit-side lane serializer feeding one serial lane (input_0/input_1) of phy_rx.

---
 rtl/phy_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_phy_tx_serializer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer
//   Transmit-side lane serializer. Bytes from the byte-parallel side are
//   queued in a small FIFO and shifted out MSB-first, one bit per clk_32f
//   cycle, in 8-cycle slots. After every reset a preamble of SYNC_BC comma
//   slots is sent. From then on, a slot carries the FIFO head when one is
//   queued and IDLE_BYTE otherwise.
//
// Ports
//   clk_32f    in   bit clock, all logic on its rising edge
//   reset      in   asynchronous active-high reset
//   data_in    in   [7:0] byte to transmit
//   valid_in   in   data_in valid
//   ready_out  out  FIFO can accept (byte taken when valid_in && ready_out)
//   serial_out out  serial bit stream, MSB of each slot byte first
//   slot_data  out  1 while the current slot carries a FIFO byte
//   sync_done  out  1 once the comma preamble has been sent
module phy_tx_serializer #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          SYNC_BC    = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       serial_out,
  output logic       slot_data,
  output logic       sync_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = (SYNC_BC > 1) ? $clog2(SYNC_BC) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [SCNT_W-1:0] SYNC_LAST = SCNT_W'(SYNC_BC - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t              state_q,      state_d;
  logic [2:0]          bit_cnt_q,    bit_cnt_d;
  logic [SCNT_W-1:0]   sync_cnt_q,   sync_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0]    count_q,      count_d;
  logic                serial_out_q, serial_out_d;
  logic                slot_data_q,  slot_data_d;
  logic                sync_done_q,  sync_done_d;
  logic [7:0]          sr_q,         sr_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic                sel_edge;
  logic                push;
  logic                pop;
  logic [7:0]          slot_byte;

  assign ready_out  = (count_q != CNT_FULL);
  assign serial_out = serial_out_q;
  assign slot_data  = slot_data_q;
  assign sync_done  = sync_done_q;

  // A slot boundary: the byte for the next 8 cycles is chosen here.
  assign sel_edge = (bit_cnt_q == 3'd0);
  assign push     = valid_in && ready_out;
  // No bypass: a byte pushed on a selection edge into an empty FIFO waits a slot.
  assign pop      = sel_edge && (state_q == ST_DATA) && (count_q != '0);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + 3'd1;
    sync_cnt_d   = sync_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    slot_data_d  = slot_data_q;
    sync_done_d  = sync_done_q;
    slot_byte    = IDLE_BYTE;
    serial_out_d = sr_q[7];
    sr_d         = {sr_q[6:0], 1'b0};

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end

    if (sel_edge) begin
      if (state_q == ST_SYNC) begin
        slot_data_d = 1'b0;
        sync_cnt_d  = sync_cnt_q + SCNT_ONE;
        if (sync_cnt_q == SYNC_LAST) begin
          state_d     = ST_DATA;
          sync_done_d = 1'b1;
        end
      end else if (pop) begin
        slot_byte   = mem_q[rd_ptr_q];
        slot_data_d = 1'b1;
      end else begin
        slot_data_d = 1'b0;
      end
      serial_out_d = slot_byte[7];
      sr_d         = {slot_byte[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      bit_cnt_q    <= '0;
      sync_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      serial_out_q <= 1'b0;
      slot_data_q  <= 1'b0;
      sync_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      serial_out_q <= serial_out_d;
      slot_data_q  <= slot_data_d;
      sync_done_q  <= sync_done_d;
    end
  end

  // Datapath storage: contents are meaningless until the control state says
  // otherwise, so it carries no reset.
  always_ff @(posedge clk_32f) begin
    sr_q <= sr_d;
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer.sv
module tb_phy_tx_serializer;

  localparam int         FIFO_DEPTH = 4;
  localparam int         SYNC_BC    = 4;
  localparam logic [7:0] IDLE_BYTE  = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       serial_out;
  logic       slot_data;
  logic       sync_done;

  phy_tx_serializer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .SYNC_BC   (SYNC_BC),
    .IDLE_BYTE (IDLE_BYTE)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .serial_out(serial_out),
    .slot_data (slot_data),
    .sync_done (sync_done)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slot-level view of the lane.
  logic [7:0] mq [$];
  int         edge_n;
  logic [7:0] cur_byte;
  logic       exp_ser, exp_slot, exp_sync, exp_rdy;

  // Bytes reconstructed from the DUT serial stream, one per completed slot.
  logic [7:0] act_sh;
  logic       act_flag;
  logic [7:0] act_bytes [$];
  logic       act_flags [$];

  task automatic model_reset();
    mq.delete();
    edge_n   = 0;
    cur_byte = 8'h00;
    exp_ser  = 1'b0;
    exp_slot = 1'b0;
    exp_sync = 1'b0;
    exp_rdy  = 1'b1;
    act_sh   = 8'h00;
    act_flag = 1'b0;
    act_bytes.delete();
    act_flags.delete();
  endtask

  // One clock edge: drive inputs, advance the model, compare all outputs.
  task automatic tick(input logic v, input logic [7:0] d);
    int   pos;
    int   slot;
    logic acc;
    valid_in = v;
    data_in  = d;
    @(posedge clk_32f);
    pos  = edge_n % 8;
    slot = edge_n / 8;
    acc  = v && (mq.size() < FIFO_DEPTH);
    if (pos == 0) begin
      if (slot < SYNC_BC) begin
        cur_byte = IDLE_BYTE;
        exp_slot = 1'b0;
        if (slot == SYNC_BC - 1) exp_sync = 1'b1;
      end else if (mq.size() > 0) begin
        cur_byte = mq.pop_front();
        exp_slot = 1'b1;
      end else begin
        cur_byte = IDLE_BYTE;
        exp_slot = 1'b0;
      end
    end
    exp_ser = cur_byte[7-pos];
    if (acc) mq.push_back(d);
    exp_rdy = (mq.size() < FIFO_DEPTH);
    edge_n++;
    #1;
    valid_in = 1'b0;
    n_checks += 4;
    if (serial_out !== exp_ser) begin
      n_fail++;
      $display("FAIL serial_out edge %0d: got %b expected %b", edge_n, serial_out, exp_ser);
    end
    if (slot_data !== exp_slot) begin
      n_fail++;
      $display("FAIL slot_data edge %0d: got %b expected %b", edge_n, slot_data, exp_slot);
    end
    if (sync_done !== exp_sync) begin
      n_fail++;
      $display("FAIL sync_done edge %0d: got %b expected %b", edge_n, sync_done, exp_sync);
    end
    if (ready_out !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready_out edge %0d: got %b expected %b", edge_n, ready_out, exp_rdy);
    end
    act_sh = {act_sh[6:0], serial_out};
    if (pos == 0) act_flag = slot_data;
    if (pos == 7) begin
      act_bytes.push_back(act_sh);
      act_flags.push_back(act_flag);
    end
  endtask

  // Hold valid_in until the byte is taken; waited = edges refused.
  task automatic push_byte(input logic [7:0] d, output int waited);
    logic done;
    done   = 1'b0;
    waited = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      done = (ready_out === 1'b1);
      tick(1'b1, d);
      if (!done) waited++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: byte %02h not accepted within 40 edges", d);
    end
  endtask

  task automatic tick_until_pos(input int p);
    for (int i = 0; i < 8 && (edge_n % 8) != p; i++) tick(1'b0, 8'h00);
  endtask

  task automatic restart();
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #1;
    n_checks += 4;
    if (serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_serial_out: got %b expected 0", serial_out); end
    if (slot_data  !== 1'b0) begin n_fail++; $display("FAIL reset_slot_data: got %b expected 0", slot_data); end
    if (sync_done  !== 1'b0) begin n_fail++; $display("FAIL reset_sync_done: got %b expected 0", sync_done); end
    if (ready_out  !== 1'b1) begin n_fail++; $display("FAIL reset_ready_out: got %b expected 1", ready_out); end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_sync_preamble();
    logic [7:0] pat;
    logic       eb;
    pat = 8'hBC;
    for (int k = 1; k <= 64; k++) begin
      tick(1'b0, 8'h00);
      eb = pat[7 - ((k - 1) % 8)];
      n_checks += 3;
      if (serial_out !== eb) begin
        n_fail++; $display("FAIL preamble_bit edge %0d: got %b expected %b", k, serial_out, eb);
      end
      if (sync_done !== (k >= 25)) begin
        n_fail++; $display("FAIL preamble_sync_done edge %0d: got %b", k, sync_done);
      end
      if (slot_data !== 1'b0) begin
        n_fail++; $display("FAIL preamble_slot_data edge %0d: got %b expected 0", k, slot_data);
      end
    end
  endtask

  task automatic test_first_byte();
    restart();
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'hA5);
    for (int k = 4; k <= 48; k++) begin
      tick(1'b0, 8'h00);
      if (k >= 33 && k <= 40) begin
        n_checks++;
        if (slot_data !== 1'b1) begin
          n_fail++; $display("FAIL first_byte_slot_data edge %0d: got %b expected 1", k, slot_data);
        end
      end
    end
    n_checks++;
    if (act_bytes.size() != 6) begin
      n_fail++; $display("FAIL first_byte_slots: got %0d slots expected 6", act_bytes.size());
    end else begin
      for (int s = 0; s < 6; s++) begin
        logic [7:0] eb;
        logic       ef;
        eb = (s == 4) ? 8'hA5 : 8'hBC;
        ef = (s == 4);
        n_checks += 2;
        if (act_bytes[s] !== eb) begin
          n_fail++; $display("FAIL first_byte_slot%0d_byte: got %02h expected %02h", s, act_bytes[s], eb);
        end
        if (act_flags[s] !== ef) begin
          n_fail++; $display("FAIL first_byte_slot%0d_flag: got %b expected %b", s, act_flags[s], ef);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int w;
    tick_until_pos(1);
    base = act_bytes.size();
    for (int b = 1; b <= 4; b++) push_byte(8'(b), w);
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", ready_out);
    end
    push_byte(8'h05, w);
    n_checks++;
    if (w !== 4) begin
      n_fail++; $display("FAIL b2b_fifth_wait: got %0d edges expected 4", w);
    end
    for (int i = 0; i < 80 && act_bytes.size() < base + 7; i++) tick(1'b0, 8'h00);
    n_checks++;
    if (act_bytes.size() < base + 7) begin
      n_fail++; $display("FAIL b2b_slots: got %0d slots expected %0d", act_bytes.size(), base + 7);
    end else begin
      for (int s = 0; s < 7; s++) begin
        logic [7:0] eb;
        logic       ef;
        ef = (s >= 1 && s <= 5);
        eb = ef ? 8'(s) : 8'hBC;
        n_checks += 2;
        if (act_bytes[base+s] !== eb) begin
          n_fail++; $display("FAIL b2b_slot%0d_byte: got %02h expected %02h", s, act_bytes[base+s], eb);
        end
        if (act_flags[base+s] !== ef) begin
          n_fail++; $display("FAIL b2b_slot%0d_flag: got %b expected %b", s, act_flags[base+s], ef);
        end
      end
    end
  endtask

  task automatic test_push_on_select();
    int base;
    tick_until_pos(0);
    base = act_bytes.size();
    tick(1'b1, 8'h3C);
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h00);
    n_checks++;
    if (act_bytes.size() < base + 2) begin
      n_fail++; $display("FAIL sel_push_slots: got %0d slots expected %0d", act_bytes.size(), base + 2);
    end else begin
      n_checks += 4;
      if (act_bytes[base] !== 8'hBC)   begin n_fail++; $display("FAIL sel_push_first_byte: got %02h expected bc", act_bytes[base]); end
      if (act_flags[base] !== 1'b0)    begin n_fail++; $display("FAIL sel_push_first_flag: got %b expected 0", act_flags[base]); end
      if (act_bytes[base+1] !== 8'h3C) begin n_fail++; $display("FAIL sel_push_next_byte: got %02h expected 3c", act_bytes[base+1]); end
      if (act_flags[base+1] !== 1'b1)  begin n_fail++; $display("FAIL sel_push_next_flag: got %b expected 1", act_flags[base+1]); end
    end
  endtask

  task automatic test_idle_as_data();
    int base;
    int w;
    tick_until_pos(1);
    base = act_bytes.size();
    push_byte(8'hBC, w);
    for (int i = 0; i < 20 && act_bytes.size() < base + 2; i++) tick(1'b0, 8'h00);
    n_checks++;
    if (act_bytes.size() < base + 2) begin
      n_fail++; $display("FAIL idle_data_slots: got %0d slots expected %0d", act_bytes.size(), base + 2);
    end else begin
      n_checks += 2;
      if (act_bytes[base+1] !== 8'hBC) begin n_fail++; $display("FAIL idle_data_byte: got %02h expected bc", act_bytes[base+1]); end
      if (act_flags[base+1] !== 1'b1)  begin n_fail++; $display("FAIL idle_data_flag: got %b expected 1", act_flags[base+1]); end
    end
  endtask

  task automatic test_reset_midslot();
    int w;
    tick_until_pos(1);
    push_byte(8'h3C, w);
    push_byte(8'h11, w);
    push_byte(8'h22, w);
    tick_until_pos(0);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
    n_checks++;
    if (slot_data !== 1'b1) begin
      n_fail++; $display("FAIL midslot_pre_slot_data: got %b expected 1", slot_data);
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_checks += 4;
    if (serial_out !== 1'b0) begin n_fail++; $display("FAIL midslot_serial_out: got %b expected 0", serial_out); end
    if (ready_out  !== 1'b1) begin n_fail++; $display("FAIL midslot_ready_out: got %b expected 1", ready_out); end
    if (sync_done  !== 1'b0) begin n_fail++; $display("FAIL midslot_sync_done: got %b expected 0", sync_done); end
    if (slot_data  !== 1'b0) begin n_fail++; $display("FAIL midslot_slot_data: got %b expected 0", slot_data); end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) tick(1'b0, 8'h00);
    n_checks++;
    if (act_bytes.size() != 8) begin
      n_fail++; $display("FAIL midslot_slots: got %0d slots expected 8", act_bytes.size());
    end else begin
      for (int s = 0; s < 8; s++) begin
        n_checks += 2;
        if (act_bytes[s] !== 8'hBC) begin n_fail++; $display("FAIL midslot_slot%0d_byte: got %02h expected bc", s, act_bytes[s]); end
        if (act_flags[s] !== 1'b0)  begin n_fail++; $display("FAIL midslot_slot%0d_flag: got %b expected 0", s, act_flags[s]); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 48; i++) tick(1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sync_preamble();
    test_first_byte();
    test_back_to_back();
    test_push_on_select();
    test_idle_as_data();
    test_reset_midslot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
